order_gen: RTL

ORDER_GEN -- requirements
Module: order_gen

---
 rtl/order_gen.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/order_gen.sv
// Order generator: confirms RSI decisions over ticks, issues valid/ready orders, tracks position.
// Optional short selling is enabled by defining ORDER_GEN_SHORT_EN.
module order_gen #(
  parameter int unsigned CONFIRM  = 2,
  parameter int unsigned COOLDOWN = 4,
  parameter logic [15:0] QTY      = 16'd100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        sig1,
  input  logic        sig2,
  input  logic        order_ready,
  output logic        order_valid,
  output logic        order_side,
  output logic [15:0] order_qty,
  output logic [1:0]  position,
  output logic        busy,
  output logic [1:0]  dbg_state,
  output logic [3:0]  dbg_confirm
);

  // Handshake: an order transfers on any rising edge where order_valid && order_ready;
  // order_valid, order_side and order_qty stay stable until then, and order_ready alone does nothing.

  typedef enum logic [1:0] {WATCH = 2'd0, PEND = 2'd1, COOL = 2'd2} state_t;

  localparam logic [1:0] POS_FLAT  = 2'd0;
  localparam logic [1:0] POS_LONG  = 2'd1;
  localparam logic [1:0] POS_SHORT = 2'd2;

  localparam logic [1:0] REQ_NONE = 2'd0;
  localparam logic [1:0] REQ_BUY  = 2'd1;
  localparam logic [1:0] REQ_SELL = 2'd2;

  localparam logic [3:0] CONFIRM_C  = 4'(CONFIRM);
  localparam logic [7:0] COOLDOWN_C = 8'(COOLDOWN);

  state_t      state_q, state_d;
  logic [1:0]  pos_q;
  logic [1:0]  prev_q;
  logic [3:0]  cnt_q;
  logic [7:0]  cool_q;
  logic        side_q;

  logic [1:0]  req;
  logic        act;
  logic [3:0]  cnt_inc;
  logic [3:0]  cnt_watch;
  logic        confirm_hit;
  logic        transfer;
  logic        cool_done;

  // {sig1,sig2}: 01 buy, 00 sell, 10 and 11 hold
  always_comb begin
    req = REQ_NONE;
    if (!sig1 && sig2)       req = REQ_BUY;
    else if (!sig1 && !sig2) req = REQ_SELL;
  end

  always_comb begin
    act = 1'b0;
    case (req)
      REQ_BUY:  act = (pos_q == POS_FLAT) || (pos_q == POS_SHORT);
`ifdef ORDER_GEN_SHORT_EN
      REQ_SELL: act = (pos_q == POS_LONG) || (pos_q == POS_FLAT);
`else
      REQ_SELL: act = (pos_q == POS_LONG);
`endif
      default:  act = 1'b0;
    endcase
  end

  // prev_q only holds an actionable request, so a match implies cnt_q is already non-zero
  always_comb begin
    cnt_inc   = (cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1;
    cnt_watch = 4'd0;
    if (act) cnt_watch = (req == prev_q) ? cnt_inc : 4'd1;
  end

  assign confirm_hit = tick && (state_q == WATCH) && act && (cnt_watch >= CONFIRM_C);
  assign transfer    = (state_q == PEND) && order_ready;
  assign cool_done   = tick && (state_q == COOL) && (cool_q <= 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WATCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WATCH: if (confirm_hit) state_d = PEND;
      PEND:  if (transfer) state_d = (COOLDOWN_C == 8'd0) ? WATCH : COOL;
      COOL:  if (cool_done) state_d = WATCH;
      default: state_d = WATCH;
    endcase
  end

  always_comb begin
    order_valid = (state_q == PEND);
    order_side  = (state_q == PEND) && side_q;
    order_qty   = (state_q == PEND) ? QTY : 16'd0;
    busy        = (state_q != WATCH);
    dbg_state   = state_q;
    dbg_confirm = cnt_q;
  end

`ifdef ORDER_GEN_SHORT_EN
  assign position = pos_q;
`else
  assign position = {1'b0, pos_q[0]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q  <= POS_FLAT;
      prev_q <= REQ_NONE;
      cnt_q  <= 4'd0;
      cool_q <= 8'd0;
      side_q <= 1'b0;
    end else begin
      case (state_q)
        WATCH: begin
          if (tick) begin
            cnt_q  <= cnt_watch;
            prev_q <= act ? req : REQ_NONE;
            if (confirm_hit) side_q <= (req == REQ_BUY);
          end
        end
        PEND: begin
          if (transfer) begin
            cnt_q  <= 4'd0;
            prev_q <= REQ_NONE;
            cool_q <= COOLDOWN_C;
            if (side_q) begin
              pos_q <= (pos_q == POS_SHORT) ? POS_FLAT : POS_LONG;
            end else if (pos_q == POS_LONG) begin
              pos_q <= POS_FLAT;
            end else begin
`ifdef ORDER_GEN_SHORT_EN
              pos_q <= POS_SHORT;
`else
              pos_q <= pos_q;
`endif
            end
          end
        end
        COOL: begin
          if (tick && cool_q != 8'd0) cool_q <= cool_q - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
